// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the call/return path: picks the next PC each enabled cycle
// and drives the return-address stack, tracking its depth and trapping over/underflow.
module pc_sequencer #(
  parameter int                ADDR_W      = 11,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 'h000,
  parameter logic [ADDR_W-1:0] IRQ_VEC     = 'h004,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  target,
  input  logic               cond,
  input  logic               irq_req,
  input  logic [ADDR_W-1:0]  stack_top,
  output logic [ADDR_W-1:0]  pc,
  output logic               push,
  output logic               pop,
  output logic [ADDR_W-1:0]  stack_in,
  output logic               irq_ack,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_SKIP = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                fault_q, fault_d;
  logic                irq_ack_q, irq_ack_d;

  logic                active;
  logic                full;
  logic                empty;
  logic [ADDR_W-1:0]   pc_inc1;
  logic [ADDR_W-1:0]   pc_inc2;

  // Gating on reset keeps the stack strobes quiet in a reset cycle, so reset always wins.
  assign active  = reset && en && (state_q == S_RUN);
  assign full    = (depth_q == DEPTH_FULL);
  assign empty   = (depth_q == '0);
  assign pc_inc1 = pc_q + ADDR_W'(1);
  assign pc_inc2 = pc_q + ADDR_W'(2);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    depth_d   = depth_q;
    fault_d   = fault_q;
    irq_ack_d = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    stack_in  = '0;

    if (active) begin
      if (irq_req) begin
        // Save the current pc so the interrupted instruction re-executes on return.
        if (full) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          push      = 1'b1;
          stack_in  = pc_q;
          pc_d      = IRQ_VEC;
          depth_d   = depth_q + DEPTH_W'(1);
          irq_ack_d = 1'b1;
        end
      end else begin
        case (op)
          OP_JUMP: pc_d = target;
          OP_CALL: begin
            if (full) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              push     = 1'b1;
              stack_in = pc_inc1;
              pc_d     = target;
              depth_d  = depth_q + DEPTH_W'(1);
            end
          end
          OP_RET: begin
            if (empty) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              pop     = 1'b1;
              pc_d    = stack_top;
              depth_d = depth_q - DEPTH_W'(1);
            end
          end
          OP_SKIP: pc_d = cond ? pc_inc2 : pc_inc1;
          OP_HOLD: pc_d = pc_q;
          default: pc_d = pc_inc1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_VEC;
      depth_q   <= '0;
      fault_q   <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      fault_q   <= fault_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign pc      = pc_q;
  assign depth   = depth_q;
  assign fault   = fault_q;
  assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: plays the role of the return stack itself and checks every cycle
// against a queue-based model of the sequencing rules.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  op;
  logic [10:0] target;
  logic        cond;
  logic        irq_req;
  logic [10:0] stack_top;
  logic [10:0] pc;
  logic        push;
  logic        pop;
  logic [10:0] stack_in;
  logic        irq_ack;
  logic [4:0]  depth;
  logic        fault;

  int total = 0;
  int bad   = 0;

  // Model state: the return stack as a queue (back = top), pc as an integer.
  logic [10:0] exp_q[$];
  int          m_pc    = 0;
  bit          m_fault = 1'b0;
  bit          m_ack   = 1'b0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .target    (target),
    .cond      (cond),
    .irq_req   (irq_req),
    .stack_top (stack_top),
    .pc        (pc),
    .push      (push),
    .pop       (pop),
    .stack_in  (stack_in),
    .irq_ack   (irq_ack),
    .depth     (depth),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the strobes, clock, check the registered state.
  task automatic step(input logic rst_n, input logic e, input logic [2:0] o,
                      input logic [10:0] t, input logic c, input logic irq);
    bit          e_push, e_pop;
    int          e_sin;
    int          n_pc;
    bit          n_fault, n_ack;
    int          dp;
    logic [10:0] rnd;
    e_push  = 0;
    e_pop   = 0;
    e_sin   = 0;
    n_pc    = m_pc;
    n_fault = m_fault;
    n_ack   = 0;
    dp      = exp_q.size();
    rnd     = 11'($urandom);

    reset     = rst_n;
    en        = e;
    op        = o;
    target    = t;
    cond      = c;
    irq_req   = irq;
    stack_top = (dp > 0) ? exp_q[dp-1] : rnd;

    if (!rst_n) begin
      n_pc    = 0;
      n_fault = 0;
    end else if (e && !m_fault) begin
      if (irq) begin
        if (dp == 16) n_fault = 1;
        else begin
          e_push = 1; e_sin = m_pc; n_pc = 4; n_ack = 1;
        end
      end else begin
        case (o)
          3'd1: n_pc = t;
          3'd2: begin
            if (dp == 16) n_fault = 1;
            else begin
              e_push = 1; e_sin = (m_pc + 1) % 2048; n_pc = t;
            end
          end
          3'd3: begin
            if (dp == 0) n_fault = 1;
            else begin
              e_pop = 1; n_pc = exp_q[dp-1];
            end
          end
          3'd4: n_pc = (m_pc + (c ? 2 : 1)) % 2048;
          3'd5: n_pc = m_pc;
          default: n_pc = (m_pc + 1) % 2048;
        endcase
      end
    end

    #1;
    chk("push", 32'(push), 32'(e_push));
    chk("pop", 32'(pop), 32'(e_pop));
    chk("stack_in", 32'(stack_in), e_sin);

    @(posedge clk);
    if (!rst_n) exp_q.delete();
    else if (e_push) exp_q.push_back(11'(e_sin));
    else if (e_pop) void'(exp_q.pop_back());
    m_pc    = n_pc;
    m_fault = n_fault;
    m_ack   = n_ack;
    #1;
    chk("pc", 32'(pc), m_pc);
    chk("depth", 32'(depth), exp_q.size());
    chk("fault", 32'(fault), 32'(m_fault));
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));
  endtask

  task automatic run(input logic [2:0] o, input logic [10:0] t);
    step(1'b1, 1'b1, o, t, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 0; en = 0; op = 0; target = 0; cond = 0; irq_req = 0; stack_top = 0;

    // Reset, then three increments.
    step(1'b0, 1'b1, 3'd0, 11'h0, 1'b0, 1'b0);
    chk("reset_pc", 32'(pc), 32'h000);
    for (int i = 0; i < 3; i++) run(3'd0, 11'h0);
    chk("next3_pc", 32'(pc), 32'h003);

    // Call/return round trip from 010.
    run(3'd1, 11'h010);
    run(3'd2, 11'h100);
    chk("call_pc", 32'(pc), 32'h100);
    chk("call_depth", 32'(depth), 32'd1);
    run(3'd0, 11'h0);
    run(3'd3, 11'h0);
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_depth", 32'(depth), 32'd0);

    // Call immediately followed by return.
    run(3'd2, 11'h234);
    run(3'd3, 11'h0);
    chk("call_ret_pc", 32'(pc), 32'h012);

    // Sixteen nested calls, then overflow into the fault state.
    for (int i = 0; i < 16; i++) run(3'd2, 11'(12'h200 + i * 4));
    chk("full_depth", 32'(depth), 32'd16);
    chk("full_nofault", 32'(fault), 32'd0);
    run(3'd2, 11'h700);
    chk("ovf_fault", 32'(fault), 32'd1);
    run(3'd3, 11'h0);
    run(3'd1, 11'h333);
    step(1'b1, 1'b1, 3'd0, 11'h0, 1'b0, 1'b1);
    chk("fault_hold_pc", 32'(pc), 32'h23c);

    // Return with an empty stack.
    step(1'b0, 1'b1, 3'd0, 11'h0, 1'b0, 1'b0);
    run(3'd3, 11'h0);
    chk("udf_fault", 32'(fault), 32'd1);
    chk("udf_pc", 32'(pc), 32'h000);
    step(1'b0, 1'b1, 3'd0, 11'h0, 1'b0, 1'b0);

    // Wrap-around arithmetic.
    run(3'd1, 11'h7ff);
    run(3'd0, 11'h0);
    chk("wrap_next", 32'(pc), 32'h000);
    run(3'd1, 11'h7fe);
    step(1'b1, 1'b1, 3'd4, 11'h0, 1'b1, 1'b0);
    chk("wrap_skip1", 32'(pc), 32'h000);
    run(3'd1, 11'h7fe);
    step(1'b1, 1'b1, 3'd4, 11'h0, 1'b0, 1'b0);
    chk("wrap_skip0", 32'(pc), 32'h7ff);
    run(3'd5, 11'h0);
    run(3'd6, 11'h0);
    run(3'd7, 11'h0);

    // Interrupt beats a CALL; a disabled cycle defers it.
    run(3'd1, 11'h020);
    step(1'b1, 1'b0, 3'd2, 11'h155, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 11'h155, 1'b0, 1'b1);
    chk("irq_pc", 32'(pc), 32'h004);
    chk("irq_ack_pulse", 32'(irq_ack), 32'd1);
    run(3'd0, 11'h0);
    chk("irq_ack_clear", 32'(irq_ack), 32'd0);
    run(3'd3, 11'h0);
    chk("irq_ret_pc", 32'(pc), 32'h020);

    // Reset during a CALL.
    run(3'd2, 11'h400);
    step(1'b0, 1'b1, 3'd2, 11'h500, 1'b0, 1'b0);
    chk("rst_call_pc", 32'(pc), 32'h000);
    chk("rst_call_depth", 32'(depth), 32'd0);

    // Randomized traffic, call-heavy so the stack reaches both ends.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_en, r_irq, r_c;
      logic [2:0]  r_op;
      r_rst = ($urandom_range(0, 59) != 0) && !(m_fault && $urandom_range(0, 3) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      r_irq = ($urandom_range(0, 11) == 0);
      r_c   = 1'($urandom);
      r_op  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r_op = 3'd2;
      step(r_rst, r_en, r_op, 11'($urandom), r_c, r_irq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
